rv_fetch_pc: RTL and testbench



---
 rtl/rv_core_pkg.sv | 25 ++
 rtl/rv_fetch_pc_if.sv | 20 ++
 rtl/rv_pc_redirect_buf.sv | 44 ++++
 rtl/rv_fetch_pc.sv | 128 ++++++++++++
 tb/tb_rv_fetch_pc.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: fetch FSM states and IALIGN-derived PC constants.
package rv_core_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam int unsigned INC_IALIGN32  = 4;
  localparam int unsigned INC_IALIGN16  = 2;
  localparam int unsigned MASK_IALIGN32 = 3;
  localparam int unsigned MASK_IALIGN16 = 1;

  function automatic int unsigned pc_inc(input int unsigned ialign);
    return (ialign == 16) ? INC_IALIGN16 : INC_IALIGN32;
  endfunction

  function automatic int unsigned align_mask(input int unsigned ialign);
    return (ialign == 16) ? MASK_IALIGN16 : MASK_IALIGN32;
  endfunction

endpackage

// File: rtl/rv_fetch_pc_if.sv
// Instruction-memory fetch request channel (valid/ready with address).
interface rv_fetch_pc_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready
  );
endinterface

// File: rtl/rv_pc_redirect_buf.sv
// Pending fetch-target register for redirects/traps that arrive while a request is stalled.
module rv_pc_redirect_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            load_trap,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            load_redir,
  input  logic [XLEN-1:0] redir_addr,
  output logic            pend_valid,
  output logic            pend_is_trap,
  output logic [XLEN-1:0] pend_addr
);

  logic            valid_q;
  logic            is_trap_q;
  logic [XLEN-1:0] addr_q;

  // A buffered trap must survive later redirects until the stalled request is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      is_trap_q <= 1'b0;
      addr_q    <= '0;
    end else if (clear) begin
      valid_q   <= 1'b0;
      is_trap_q <= 1'b0;
    end else if (load_trap) begin
      valid_q   <= 1'b1;
      is_trap_q <= 1'b1;
      addr_q    <= trap_addr;
    end else if (load_redir && !is_trap_q) begin
      valid_q   <= 1'b1;
      addr_q    <= redir_addr;
    end
  end

  assign pend_valid   = valid_q;
  assign pend_is_trap = is_trap_q;
  assign pend_addr    = addr_q;

endmodule

// File: rtl/rv_fetch_pc.sv
// RV32 program counter and fetch-request unit: holds the PC, selects next-PC
// (sequential, redirect, trap, buffered target) and drives the imem request channel.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_BOOT   | one cycle after reset release, no request issued
//   ST_FETCH  | issuing requests (valid registers high one cycle after entry)
//   ST_HALTED | halt asserted, no request issued; PC still takes trap/redirect
module rv_fetch_pc
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int unsigned     IALIGN       = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  rv_fetch_pc_if.master   imem,
  input  logic            redirect_valid,
  input  logic            redirect_sel,
  input  logic [XLEN-1:0] alu_imm_pc_next,
  input  logic [XLEN-1:0] imm_offset,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  output logic [XLEN-1:0] pc_value,
  output logic [XLEN-1:0] pc_alu,
  output logic [XLEN-1:0] pc_plus,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] INC  = XLEN'(pc_inc(IALIGN));
  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(IALIGN));

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            misaligned_q;

  logic            accept;
  logic            direct_upd;
  logic            stalled;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] trap_target;
  logic            redir_misaligned;
  logic            redir_ok;
  logic            load_trap;
  logic            load_redir;
  logic            pend_valid;
  logic            pend_is_trap;
  logic [XLEN-1:0] pend_addr;

  assign pc_alu           = pc_q + imm_offset;
  assign pc_plus          = pc_q + INC;
  assign redir_target     = redirect_sel ? pc_alu : alu_imm_pc_next;
  assign redir_misaligned = (redir_target & MASK) != '0;
  assign redir_ok         = redirect_valid && !redir_misaligned;
  assign trap_target      = trap_vector & ~MASK;

  assign accept     = valid_q && imem.imem_req_ready;
  assign stalled    = valid_q && !imem.imem_req_ready;
  assign direct_upd = !valid_q;
  assign load_trap  = stalled && trap_valid;
  assign load_redir = stalled && redir_ok;

  rv_pc_redirect_buf #(
    .XLEN (XLEN)
  ) u_redirect_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (accept),
    .load_trap    (load_trap),
    .trap_addr    (trap_target),
    .load_redir   (load_redir),
    .redir_addr   (redir_target),
    .pend_valid   (pend_valid),
    .pend_is_trap (pend_is_trap),
    .pend_addr    (pend_addr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:   state_d = halt ? ST_HALTED : ST_FETCH;
      ST_FETCH:  if (halt && (accept || !valid_q)) state_d = ST_HALTED;
      ST_HALTED: if (!halt) state_d = ST_FETCH;
      default:   state_d = ST_BOOT;
    endcase
    valid_d = (state_q == ST_FETCH) && (state_d == ST_FETCH);
  end

  // A pending trap outranks a live redirect so a redirect can never cancel a taken trap.
  always_comb begin
    pc_d = pc_q;
    if (accept || direct_upd) begin
      if (trap_valid)
        pc_d = trap_target;
      else if (accept && pend_valid && pend_is_trap)
        pc_d = pend_addr;
      else if (redir_ok)
        pc_d = redir_target;
      else if (accept && pend_valid)
        pc_d = pend_addr;
      else if (accept)
        pc_d = pc_plus;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      misaligned_q <= redirect_valid && redir_misaligned;
    end
  end

  assign imem.imem_req_valid = valid_q;
  assign imem.imem_req_addr  = pc_q;
  assign pc_value            = pc_q;
  assign misaligned          = misaligned_q;

endmodule

// File: tb/tb_rv_fetch_pc.sv
// Bench for rv_fetch_pc: IALIGN=32 instance under full test, IALIGN=16 instance for alignment.
module tb_rv_fetch_pc;

  logic        clk;
  logic        reset_n;
  logic        ready;
  logic        redirect_valid;
  logic        redirect_sel;
  logic [31:0] alu_imm_pc_next;
  logic [31:0] imm_offset;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt;

  logic [31:0] pc32, alu32, plus32;
  logic        mis32;
  logic [31:0] pc16, alu16, plus16;
  logic        mis16;

  int          n_pass;
  int          n_checks;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  rv_fetch_pc_if #(.XLEN(32)) imem32 ();
  rv_fetch_pc_if #(.XLEN(32)) imem16 ();

  assign imem32.imem_req_ready = ready;
  assign imem16.imem_req_ready = ready;

  rv_fetch_pc #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) dut32 (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem            (imem32.master),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .alu_imm_pc_next (alu_imm_pc_next),
    .imm_offset      (imm_offset),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt            (halt),
    .pc_value        (pc32),
    .pc_alu          (alu32),
    .pc_plus         (plus32),
    .misaligned      (mis32)
  );

  rv_fetch_pc #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) dut16 (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem            (imem16.master),
    .redirect_valid  (redirect_valid),
    .redirect_sel    (redirect_sel),
    .alu_imm_pc_next (alu_imm_pc_next),
    .imm_offset      (imm_offset),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .halt            (halt),
    .pc_value        (pc16),
    .pc_alu          (alu16),
    .pc_plus         (plus16),
    .misaligned      (mis16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    ready   = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pc32 !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc32, 32'h0);
    else n_pass++;
    n_checks++;
    if (imem32.imem_req_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", imem32.imem_req_valid);
    else n_pass++;
    n_checks++;
    if (mis32 !== 1'b0) $display("FAIL reset_misaligned: got %b expected 0", mis32);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b0) $display("FAIL boot_valid: got %b expected 0", imem32.imem_req_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b expected 1", imem32.imem_req_valid);
    else n_pass++;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL reset_seq_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL reset_seq_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect_alu();
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'hFF00_FF00;
    exp_q.push_back(32'hFF00_FF00);
    exp_q.push_back(32'hFF00_FF04);
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (plus32 !== 32'hFF00_FF04) $display("FAIL redirect_pc_plus: got %h expected %h", plus32, 32'hFF00_FF04);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL redirect_alu_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL redirect_alu_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_stall_redirect();
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'h10;
    @(negedge clk);
    ready        = 1'b0;
    redirect_sel = 1'b1;
    imm_offset   = 32'd400;
    #1;
    n_checks++;
    if (alu32 !== 32'h1A0) $display("FAIL stall_pc_alu: got %h expected %h", alu32, 32'h1A0);
    else n_pass++;
    n_checks++;
    if (plus32 !== 32'h14) $display("FAIL stall_pc_plus: got %h expected %h", plus32, 32'h14);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    imm_offset     = 32'h0;
    n_checks++;
    if (imem32.imem_req_addr !== 32'h10) $display("FAIL stall_hold_addr: got %h expected %h", imem32.imem_req_addr, 32'h10);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b1 || imem32.imem_req_addr !== 32'h10)
      $display("FAIL stall_hold_valid: got %b/%h expected 1/%h", imem32.imem_req_valid, imem32.imem_req_addr, 32'h10);
    else n_pass++;
    ready = 1'b1;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h1A0);
    exp_q.push_back(32'h1A4);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL stall_seq_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL stall_seq_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_trap_priority();
    ready           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    trap_valid     = 1'b1;
    trap_vector    = 32'h803;
    n_checks++;
    if (imem32.imem_req_addr !== 32'h1A4) $display("FAIL trap_stall_addr: got %h expected %h", imem32.imem_req_addr, 32'h1A4);
    else n_pass++;
    @(negedge clk);
    trap_valid      = 1'b0;
    redirect_valid  = 1'b1;
    alu_imm_pc_next = 32'h300;
    n_checks++;
    if (imem32.imem_req_addr !== 32'h1A4) $display("FAIL trap_stall_addr2: got %h expected %h", imem32.imem_req_addr, 32'h1A4);
    else n_pass++;
    @(negedge clk);
    redirect_valid = 1'b0;
    ready          = 1'b1;
    exp_q.push_back(32'h1A4);
    exp_q.push_back(32'h800);
    exp_q.push_back(32'h804);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL trap_seq_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL trap_seq_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_misaligned();
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'h102;
    exp_q.push_back(32'h808);
    exp_q.push_back(32'h80C);
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (mis32 !== 1'b1) $display("FAIL misaligned_pulse: got %b expected 1", mis32);
    else n_pass++;
    n_checks++;
    if (mis16 !== 1'b0) $display("FAIL ialign16_misaligned: got %b expected 0", mis16);
    else n_pass++;
    n_checks++;
    if (pc16 !== 32'h102 || imem16.imem_req_addr !== 32'h102)
      $display("FAIL ialign16_target: got %h/%h expected %h", pc16, imem16.imem_req_addr, 32'h102);
    else n_pass++;
    n_checks++;
    if (plus16 !== 32'h104 || alu16 !== 32'h102)
      $display("FAIL ialign16_adders: got %h/%h expected %h/%h", plus16, alu16, 32'h104, 32'h102);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL misaligned_seq_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL misaligned_seq_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (mis32 !== 1'b0) $display("FAIL misaligned_pulse_width: got %b expected 0", mis32);
    else n_pass++;
    ready           = 1'b0;
    redirect_valid  = 1'b1;
    alu_imm_pc_next = 32'h206;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (mis32 !== 1'b1) $display("FAIL misaligned_stall_pulse: got %b expected 1", mis32);
    else n_pass++;
    ready = 1'b1;
    exp_q.push_back(32'h80C);
    exp_q.push_back(32'h810);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL misaligned_stall_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL misaligned_stall_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b0 || pc32 !== 32'h814)
      $display("FAIL halt_after_accept: got %b/%h expected 0/%h", imem32.imem_req_valid, pc32, 32'h814);
    else n_pass++;
    trap_valid  = 1'b1;
    trap_vector = 32'h40;
    @(negedge clk);
    trap_valid = 1'b0;
    n_checks++;
    if (pc32 !== 32'h40 || imem32.imem_req_valid !== 1'b0)
      $display("FAIL halted_trap: got %h/%b expected %h/0", pc32, imem32.imem_req_valid, 32'h40);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b0) $display("FAIL halted_stays: got %b expected 0", imem32.imem_req_valid);
    else n_pass++;
    halt = 1'b0;
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL halt_resume_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL halt_resume_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
    ready = 1'b0;
    halt  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b1 || imem32.imem_req_addr !== 32'h44)
      $display("FAIL halt_waits_accept: got %b/%h expected 1/%h", imem32.imem_req_valid, imem32.imem_req_addr, 32'h44);
    else n_pass++;
    ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem32.imem_req_valid !== 1'b0 || pc32 !== 32'h48)
      $display("FAIL halt_on_late_accept: got %b/%h expected 0/%h", imem32.imem_req_valid, pc32, 32'h48);
    else n_pass++;
    halt = 1'b0;
    exp_q.push_back(32'h48);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL halt_resume2_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL halt_resume2_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (plus32 !== 32'h0) $display("FAIL wrap_pc_plus: got %h expected %h", plus32, 32'h0);
    else n_pass++;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL wrap_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL wrap_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    ready           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'h500;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pc32 !== 32'h0 || imem32.imem_req_valid !== 1'b0)
      $display("FAIL async_reset: got %h/%b expected %h/0", pc32, imem32.imem_req_valid, 32'h0);
    else n_pass++;
    @(negedge clk);
    ready   = 1'b1;
    reset_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 0; c < 16; c++) begin
      if (imem32.imem_req_valid && ready) begin
        exp_addr = exp_q.pop_front();
        n_checks++;
        if (imem32.imem_req_addr !== exp_addr) $display("FAIL reset_mid_addr: got %h expected %h", imem32.imem_req_addr, exp_addr);
        else n_pass++;
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL reset_mid_timeout: got %0d unfetched expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    n_pass          = 0;
    n_checks        = 0;
    reset_n         = 1'b0;
    ready           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_sel    = 1'b0;
    alu_imm_pc_next = 32'h0;
    imm_offset      = 32'h0;
    trap_valid      = 1'b0;
    trap_vector     = 32'h0;
    halt            = 1'b0;
    test_reset();
    test_redirect_alu();
    test_stall_redirect();
    test_trap_priority();
    test_misaligned();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
